// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter that owns one SPI mode-0 master.
// The winner's word goes out MSB first; the word received on MISO is returned on rdata.
module spi_arbiter #(
  parameter int DATA_W   = 16,
  parameter int HALF_DIV = 25
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              SCLK,
  output logic              CS_N,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [7:0]       HALF_LAST = 8'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_END   = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t            state_reg;
  logic [7:0]        half_cnt_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              owner_reg;
  logic              last_reg;
  logic              gnt0_reg;
  logic              gnt1_reg;
  logic              done0_reg;
  logic              done1_reg;
  logic              busy_reg;
  logic              sclk_reg;
  logic              cs_n_reg;
  logic              mosi_reg;

  logic half_end;
  logic pick1;

  assign half_end = (half_cnt_reg == HALF_LAST);

  // last_reg holds the requester granted most recently; a tie goes to the other one.
  always_comb begin
    pick1 = 1'b0;
    if (req0 && req1) begin
      pick1 = ~last_reg;
    end else if (req1) begin
      pick1 = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      rdata_reg    <= '0;
      owner_reg    <= 1'b0;
      last_reg     <= 1'b1;
      gnt0_reg     <= 1'b0;
      gnt1_reg     <= 1'b0;
      done0_reg    <= 1'b0;
      done1_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      sclk_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
      mosi_reg     <= 1'b0;
    end else begin
      gnt0_reg  <= 1'b0;
      gnt1_reg  <= 1'b0;
      done0_reg <= 1'b0;
      done1_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req0 || req1) begin
            state_reg    <= SETUP;
            half_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            owner_reg    <= pick1;
            last_reg     <= pick1;
            gnt0_reg     <= ~pick1;
            gnt1_reg     <= pick1;
            tx_reg       <= pick1 ? wdata1 : wdata0;
            mosi_reg     <= pick1 ? wdata1[DATA_W-1] : wdata0[DATA_W-1];
            rx_reg       <= '0;
            cs_n_reg     <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        SETUP: begin
          if (half_end) begin
            state_reg    <= SHIFT;
            half_cnt_reg <= '0;
            sclk_reg     <= 1'b1;
            rx_reg       <= {rx_reg[DATA_W-2:0], MISO};
          end else begin
            half_cnt_reg <= half_cnt_reg + 8'd1;
          end
        end
        SHIFT: begin
          if (!half_end) begin
            half_cnt_reg <= half_cnt_reg + 8'd1;
          end else begin
            half_cnt_reg <= '0;
            if (sclk_reg) begin
              sclk_reg    <= 1'b0;
              bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
              // The last falling edge leaves the final bit on MOSI through HOLD.
              if (bit_cnt_reg != BIT_LAST) begin
                tx_reg   <= {tx_reg[DATA_W-2:0], 1'b0};
                mosi_reg <= tx_reg[DATA_W-2];
              end
            end else if (bit_cnt_reg == BIT_END) begin
              state_reg <= HOLD;
            end else begin
              sclk_reg <= 1'b1;
              rx_reg   <= {rx_reg[DATA_W-2:0], MISO};
            end
          end
        end
        HOLD: begin
          if (half_end) begin
            state_reg    <= GAP;
            half_cnt_reg <= '0;
            cs_n_reg     <= 1'b1;
            mosi_reg     <= 1'b0;
            rdata_reg    <= rx_reg;
            done0_reg    <= ~owner_reg;
            done1_reg    <= owner_reg;
          end else begin
            half_cnt_reg <= half_cnt_reg + 8'd1;
          end
        end
        GAP: begin
          if (half_end) begin
            state_reg    <= IDLE;
            half_cnt_reg <= '0;
            busy_reg     <= 1'b0;
          end else begin
            half_cnt_reg <= half_cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt0  = gnt0_reg;
  assign gnt1  = gnt1_reg;
  assign done0 = done0_reg;
  assign done1 = done1_reg;
  assign rdata = rdata_reg;
  assign busy  = busy_reg;
  assign SCLK  = sclk_reg;
  assign CS_N  = cs_n_reg;
  assign MOSI  = mosi_reg;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: transfer-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spi_arbiter;

  localparam int DATA_W   = 16;
  localparam int HALF_DIV = 2;
  localparam int XFER     = (2 * DATA_W + 2) * HALF_DIV;
  localparam int SPAN     = XFER + HALF_DIV;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              req0 = 1'b0;
  logic              req1 = 1'b0;
  logic [DATA_W-1:0] wdata0 = '0;
  logic [DATA_W-1:0] wdata1 = '0;
  logic              gnt0, gnt1, done0, done1, busy, SCLK, CS_N, MOSI;
  logic [DATA_W-1:0] rdata;
  logic              MISO;
  logic              miso_drv = 1'b0;
  logic              loop_en = 1'b0;

  assign MISO = loop_en ? MOSI : miso_drv;

  spi_arbiter #(.DATA_W(DATA_W), .HALF_DIV(HALF_DIV)) dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one transfer is a fixed timeline indexed by k cycles since its grant.
  bit                m_active = 1'b0;
  int                m_k = 0;
  int                m_owner = 0;
  int                m_last = 1;
  int                nk;
  logic [DATA_W-1:0] m_data = '0;
  logic [DATA_W-1:0] m_rx = '0;
  logic [DATA_W-1:0] m_rdata = '0;
  bit                win_abort = 1'b0;
  bit                high_abort = 1'b1;

  initial forever begin
    @(posedge CLK);
    cyc++;
    if (RST) begin
      m_active   = 1'b0;
      m_rdata    = '0;
      m_last     = 1;
      win_abort  = 1'b1;
      high_abort = 1'b1;
    end else if (m_active) begin
      nk = m_k + 1;
      if (nk >= HALF_DIV && (nk - HALF_DIV) % (2 * HALF_DIV) == 0 &&
          (nk - HALF_DIV) / (2 * HALF_DIV) < DATA_W)
        m_rx = {m_rx[DATA_W-2:0], MISO};
      m_k = nk;
      if (m_k == XFER) begin
        m_rdata = m_rx;
        $display("[TB] xfer owner=%0d wdata=%h rdata_exp=%h done_cycle=%0d", m_owner, m_data, m_rdata, cyc);
      end
      if (m_k == SPAN) m_active = 1'b0;
    end else if (req0 || req1) begin
      if (req0 && req1) m_owner = (m_last == 1) ? 0 : 1;
      else              m_owner = req0 ? 0 : 1;
      m_data   = (m_owner == 0) ? wdata0 : wdata1;
      m_last   = m_owner;
      m_active = 1'b1;
      m_k      = 0;
      m_rx     = '0;
    end
  end

  // Per-cycle comparison of every output against the model.
  logic e_sclk, e_csn, e_mosi, e_busy, e_g0, e_g1, e_d0, e_d1;
  int   e_bi;

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      e_sclk = 1'b0; e_csn = 1'b1; e_mosi = 1'b0; e_busy = 1'b0;
      e_g0 = 1'b0; e_g1 = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
      if (m_active) begin
        e_busy = 1'b1;
        e_csn  = (m_k >= XFER);
        e_sclk = (m_k >= HALF_DIV) && (m_k < HALF_DIV + 2 * DATA_W * HALF_DIV) &&
                 (((m_k - HALF_DIV) / HALF_DIV) % 2 == 0);
        e_bi = m_k / (2 * HALF_DIV);
        if (e_bi > DATA_W - 1) e_bi = DATA_W - 1;
        e_mosi = (m_k < XFER) ? m_data[DATA_W-1-e_bi] : 1'b0;
        e_g0 = (m_k == 0) && (m_owner == 0);
        e_g1 = (m_k == 0) && (m_owner == 1);
        e_d0 = (m_k == XFER) && (m_owner == 0);
        e_d1 = (m_k == XFER) && (m_owner == 1);
      end
      check("sclk", SCLK, e_sclk);
      check("cs_n", CS_N, e_csn);
      check("mosi", MOSI, e_mosi);
      check("busy", busy, e_busy);
      check("gnt0", gnt0, e_g0);
      check("gnt1", gnt1, e_g1);
      check("done0", done0, e_d0);
      check("done1", done1, e_d1);
      check("rdata", rdata, m_rdata);
    end
  end

  // Bus monitor: SCLK rising edges per CS_N window, MOSI bits seen at them, CS_N high time.
  logic              sclk_prev = 1'b0;
  logic              csn_prev = 1'b1;
  int                rises = 0;
  int                high_run = 0;
  logic [DATA_W-1:0] seq = '0;
  logic [DATA_W-1:0] last_seq = '0;

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      if (csn_prev && !CS_N) begin
        if (!high_abort) check("csn_high_min", high_run >= HALF_DIV, 1);
        rises = 0; seq = '0; win_abort = 1'b0; high_abort = 1'b0;
      end
      if (!CS_N && SCLK && !sclk_prev) begin
        rises++;
        seq = {seq[DATA_W-2:0], MOSI};
      end
      if (!csn_prev && CS_N) begin
        if (!win_abort) begin
          check("sclk_rises", rises, DATA_W);
          last_seq = seq;
        end
        high_abort = win_abort;
        high_run = 0;
      end
      if (CS_N) high_run++;
    end
    sclk_prev = SCLK;
    csn_prev  = CS_N;
  end

  // sel: 0 gnt0, 1 gnt1, 2 done0, 3 done1, 4 any gnt. at = cycle seen, or -1 on timeout.
  task automatic wait_for(input int sel, input int budget, output int at);
    int i;
    at = -1;
    i = 0;
    while (at < 0 && i < budget) begin
      @(negedge CLK);
      if ((sel == 0 && gnt0) || (sel == 1 && gnt1) || (sel == 2 && done0) ||
          (sel == 3 && done1) || (sel == 4 && (gnt0 || gnt1)))
        at = cyc;
      i++;
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  int at_g, at_d;

  initial begin
    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    check("rst_cs_n", CS_N, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Loopback transfer of 0xA5C3 from requester 0.
    loop_en = 1'b1; wdata0 = 16'hA5C3; req0 = 1'b1;
    wait_for(0, 10, at_g);
    req0 = 1'b0;
    check("loop_gnt0_seen", at_g >= 0, 1);
    wait_for(2, 200, at_d);
    check("loop_xfer_len", at_d - at_g, 68);
    check("loop_rdata", rdata, 16'hA5C3);
    @(negedge CLK);
    check("loop_mosi_bits", last_seq, 16'hA5C3);
    repeat (HALF_DIV + 2) @(negedge CLK);

    // Both requesting from reset; reset wins over the requests in the same cycle.
    loop_en = 1'b0; miso_drv = 1'b0;
    RST = 1'b1; req0 = 1'b1; req1 = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_priority_no_gnt", {gnt1, gnt0}, 2'b00);
    wait_for(4, 10, at_g);
    check("tie_first", {gnt1, gnt0}, 2'b01);
    wait_for(4, 200, at_g);
    check("tie_second", {gnt1, gnt0}, 2'b10);
    wait_for(4, 200, at_g);
    check("tie_third", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    wait_for(2, 200, at_d);
    check("tie_third_done", at_d >= 0, 1);
    repeat (HALF_DIV + 2) @(negedge CLK);

    // MISO tied high, zero word from requester 1.
    miso_drv = 1'b1; wdata1 = 16'h0000; req1 = 1'b1;
    wait_for(1, 10, at_g);
    req1 = 1'b0;
    wait_for(3, 200, at_d);
    check("ones_done1_seen", at_d >= 0, 1);
    check("ones_rdata", rdata, 16'hFFFF);
    repeat (HALF_DIV + 2) @(negedge CLK);

    // Reset pulse during bit 7 of SHIFT aborts without a done.
    miso_drv = 1'b0; wdata0 = 16'h3C5A; req0 = 1'b1;
    wait_for(0, 10, at_g);
    req0 = 1'b0;
    repeat (31) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_cs_n", CS_N, 1);
    check("abort_sclk", SCLK, 0);
    wait_for(2, 80, at_d);
    check("abort_no_done", at_d, -1);
    req0 = 1'b1; req1 = 1'b1;
    wait_for(4, 10, at_g);
    check("abort_tie_gnt", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    wait_for(2, 200, at_d);
    repeat (HALF_DIV + 2) @(negedge CLK);

    // A brief req1 during a requester-0 transfer must not be remembered.
    req0 = 1'b1;
    wait_for(0, 10, at_g);
    req0 = 1'b0;
    repeat (10) @(negedge CLK);
    req1 = 1'b1;
    @(negedge CLK);
    req1 = 1'b0;
    wait_for(2, 200, at_d);
    wait_for(4, 80, at_g);
    check("pulse_no_gnt", at_g, -1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      RST = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) req0 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) req1 = 1'($urandom_range(0, 1));
      wdata0   = 16'($urandom);
      wdata1   = 16'($urandom);
      miso_drv = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    RST = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (100) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
